ad9516_spi_writer: RTL and testbench

Sequencer and SPI master that walks the AD9516 register look-up table, serialises each {address, data} entry as a single-byte 3-wire SPI write and stops at the all-ones terminator entry. It sits directly upstream of the register table: it drives `lut_index`, samples the combinational `lut_data` and drives the AD9516 pins on the ADDA board. It also reports busy/done/error status to the rest of the clocking logic.

---
 rtl/ad9516_pkg.sv | 26 ++
 rtl/ad9516_spi_writer_shift24.sv | 80 ++++++++
 rtl/ad9516_spi_writer.sv | 145 ++++++++++++++
 tb/tb_ad9516_spi_writer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad9516_pkg.sv
// Shared constants, frame format and sequencer state encoding for the AD9516 SPI writer.
package ad9516_pkg;

    localparam logic [15:0] TERM_ADDR      = 16'hFFFF;
    localparam logic [15:0] IO_UPDATE_ADDR = 16'h0232;
    localparam int unsigned FRAME_W        = 24;
    localparam logic [2:0]  INSTR_PREFIX   = 3'b000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_FETCH,
        S_CHECK,
        S_SHIFT,
        S_CS_HOLD,
        S_GAP,
        S_DONE
    } state_t;

    // Single-byte write instruction; the chip only decodes 13 address bits.
    function automatic logic [FRAME_W-1:0] build_frame(input logic [15:0] addr,
                                                       input logic [7:0]  data);
        return {INSTR_PREFIX, addr[12:0], data};
    endfunction

endpackage

// File: rtl/ad9516_spi_writer_shift24.sv
// 24-bit 3-wire SPI write shifter: MSB first, SCLK idle low, one CLK_DIV hold before CSN rises.
module spi_shift24
    import ad9516_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic [FRAME_W-1:0] i_frame,
    output logic               o_busy,
    output logic               o_hold,
    output logic               o_last,
    output logic               o_spi_csn,
    output logic               o_spi_sclk,
    output logic               o_spi_sdio
);

    localparam logic [5:0] LAST_HALF = 6'(2 * FRAME_W);

    logic               r_active;
    logic [15:0]        r_div;
    logic [5:0]         r_half;
    logic [FRAME_W-1:0] r_sh;
    logic               r_csn;
    logic               r_sclk;
    logic               r_sdio;
    logic               w_tick;

    assign w_tick     = (r_div == 16'(CLK_DIV - 1));
    assign o_busy     = r_active;
    assign o_hold     = r_active && (r_half == LAST_HALF);
    assign o_last     = o_hold && w_tick;
    assign o_spi_csn  = r_csn;
    assign o_spi_sclk = r_sclk;
    assign o_spi_sdio = r_sdio;

    // Even half-periods are SCLK-low (data changes), odd are SCLK-high; half 48 is the CSN hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= 1'b0;
            r_div    <= '0;
            r_half   <= '0;
            r_sh     <= '0;
            r_csn    <= 1'b1;
            r_sclk   <= 1'b0;
            r_sdio   <= 1'b0;
        end else if (i_load && !r_active) begin
            r_active <= 1'b1;
            r_div    <= '0;
            r_half   <= '0;
            r_sh     <= {i_frame[FRAME_W-2:0], 1'b0};
            r_csn    <= 1'b0;
            r_sclk   <= 1'b0;
            r_sdio   <= i_frame[FRAME_W-1];
        end else if (r_active) begin
            if (!w_tick) begin
                r_div <= r_div + 16'd1;
            end else begin
                r_div <= '0;
                if (r_half == LAST_HALF) begin
                    r_active <= 1'b0;
                    r_csn    <= 1'b1;
                end else begin
                    r_half <= r_half + 6'd1;
                    if (!r_half[0]) begin
                        r_sclk <= 1'b1;
                    end else begin
                        r_sclk <= 1'b0;
                        if (r_half != LAST_HALF - 6'd1) begin
                            r_sdio <= r_sh[FRAME_W-1];
                            r_sh   <= {r_sh[FRAME_W-2:0], 1'b0};
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/ad9516_spi_writer.sv
// Walks the AD9516 register table and writes each entry over 3-wire SPI until the terminator.
module ad9516_spi_writer
    import ad9516_pkg::*;
#(
    parameter int unsigned CLK_DIV       = 4,
    parameter int unsigned STARTUP_DELAY = 1000,
    parameter int unsigned CS_GAP        = 4,
    parameter int unsigned UPDATE_WAIT   = 20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [9:0]  lut_index,
    input  logic [24:0] lut_data,
    output logic        spi_csn,
    output logic        spi_sclk,
    output logic        spi_sdio,
    output logic        busy,
    output logic        done,
    output logic        err
);

    state_t             r_state;
    state_t             w_next;
    logic [31:0]        r_cnt;
    logic [9:0]         r_index;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic               r_upd;
    logic [15:0]        w_addr;
    logic [7:0]         w_data;
    logic               w_pad_unused;
    logic               w_term;
    logic               w_upd;
    logic               w_load;
    logic [FRAME_W-1:0] w_frame;
    logic               w_spi_busy;
    logic               w_hold;
    logic               w_last;

    assign w_addr       = lut_data[23:8];
    assign w_data       = lut_data[7:0];
    assign w_pad_unused = lut_data[24];
    assign w_term       = (w_addr == TERM_ADDR);
    assign w_upd        = (w_addr == IO_UPDATE_ADDR) && w_data[0];
    assign w_frame      = build_frame(w_addr, w_data);
    assign w_load       = (r_state == S_CHECK) && !w_term && !w_spi_busy;

    assign lut_index = r_index;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

    spi_shift24 #(
        .CLK_DIV(CLK_DIV)
    ) u_shift (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_frame   (w_frame),
        .o_busy    (w_spi_busy),
        .o_hold    (w_hold),
        .o_last    (w_last),
        .o_spi_csn (spi_csn),
        .o_spi_sclk(spi_sclk),
        .o_spi_sdio(spi_sdio)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // With CLK_DIV=1 the hold phase is a single cycle, so SHIFT may jump straight to GAP.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = S_DELAY;
            S_DELAY:   if (r_cnt == '0) w_next = S_FETCH;
            S_FETCH:   w_next = S_CHECK;
            S_CHECK:   w_next = w_term ? S_DONE : S_SHIFT;
            S_SHIFT: begin
                if (w_last)      w_next = S_GAP;
                else if (w_hold) w_next = S_CS_HOLD;
            end
            S_CS_HOLD: if (w_last) w_next = S_GAP;
            S_GAP: begin
                if (r_cnt == '0) w_next = (r_index == 10'd1023) ? S_DONE : S_FETCH;
            end
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_index <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_upd   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_index <= '0;
                        r_cnt   <= 32'(STARTUP_DELAY - 1);
                    end
                end
                S_DELAY: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - 32'd1;
                end
                S_CHECK: begin
                    if (w_term) begin
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end else begin
                        r_upd <= w_upd;
                    end
                end
                S_SHIFT, S_CS_HOLD: begin
                    if (w_last) r_cnt <= 32'(CS_GAP - 1) + (r_upd ? 32'(UPDATE_WAIT) : 32'd0);
                end
                S_GAP: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 32'd1;
                    end else if (r_index == 10'd1023) begin
                        r_err  <= 1'b1;
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end else begin
                        r_index <= r_index + 10'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ad9516_spi_writer.sv
// Scoreboard bench: instance A walks directed tables, instance B runs a table with no terminator.
module tb_ad9516_spi_writer;

    localparam int unsigned A_DIV = 2, A_DLY = 10, A_GAP = 4, A_UW = 50;
    localparam int unsigned B_DIV = 1, B_DLY = 2,  B_GAP = 1, B_UW = 3;
    localparam int unsigned A_PER = 2 + 49 * A_DIV + A_GAP;

    typedef struct {
        logic [23:0] frame;
        int unsigned period;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, start_a, csn_a, sclk_a, sdio_a, busy_a, done_a, err_a;
    logic        rst_b, start_b, csn_b, sclk_b, sdio_b, busy_b, done_b, err_b;
    logic [9:0]  idx_a, idx_b;
    logic [24:0] data_a, data_b;
    int          mode_a;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t        sb[$];
    logic [23:0] cap[$];

    ad9516_spi_writer #(
        .CLK_DIV(A_DIV), .STARTUP_DELAY(A_DLY), .CS_GAP(A_GAP), .UPDATE_WAIT(A_UW)
    ) u_dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .lut_index(idx_a), .lut_data(data_a),
        .spi_csn(csn_a), .spi_sclk(sclk_a), .spi_sdio(sdio_a),
        .busy(busy_a), .done(done_a), .err(err_a)
    );

    ad9516_spi_writer #(
        .CLK_DIV(B_DIV), .STARTUP_DELAY(B_DLY), .CS_GAP(B_GAP), .UPDATE_WAIT(B_UW)
    ) u_dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .lut_index(idx_b), .lut_data(data_b),
        .spi_csn(csn_b), .spi_sclk(sclk_b), .spi_sdio(sdio_b),
        .busy(busy_b), .done(done_b), .err(err_b)
    );

    function automatic logic [24:0] prod_entry(input int unsigned i);
        logic [15:0] a;
        logic [7:0]  d;
        if (i == 0)       begin a = 16'h0000; d = 8'h18; end
        else if (i == 5)  begin a = 16'hA0F0; d = 8'h3C; end
        else if (i < 67)  begin a = 16'h0010 + 16'(i); d = 8'(i * 7 + 1); end
        else if (i == 67) begin a = 16'h0232; d = 8'h00; end
        else if (i < 75)  begin a = 16'h0140 + 16'(i - 68); d = 8'h42; end
        else if (i == 75) begin a = 16'h0232; d = 8'h01; end
        else return '1;
        return {1'(i % 2), a, d};
    endfunction

    function automatic logic [24:0] table_a(input int m, input logic [9:0] i);
        case (m)
            0: return prod_entry(int'(i));
            1, 2: begin
                if (i == 10'd0) return {1'b0, 16'h0232, (m == 1) ? 8'h01 : 8'h00};
                if (i == 10'd1) return {1'b1, 16'h0085, 8'h5A};
                return '1;
            end
            default: return '1;
        endcase
    endfunction

    assign data_a = table_a(mode_a, idx_a);
    assign data_b = {1'b0, 6'd0, idx_b, ~idx_b[7:0]};

    function automatic logic [23:0] exp_frame(input logic [24:0] e);
        logic [15:0] a;
        a = e[23:8];
        return {3'b000, a[12:0], e[7:0]};
    endfunction

    function automatic logic [23:0] cap_at(input int i);
        if (cap.size() > i) return cap[i];
        return '1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_prod();
        for (int unsigned i = 0; i < 76; i++)
            sb.push_back('{exp_frame(prod_entry(i)), (i == 0) ? 0 : A_PER});
    endtask

    // ---------------- monitor A ----------------
    logic        pcsn_a = 1'b1, psclk_a = 1'b0, psdio_a = 1'b0;
    logic        in_a = 1'b0, have_fall_a = 1'b0;
    int          cyc_a = 0, fall_a = 0, per_a = 0, lo_a = 0, rises_a = 0, unst_a = 0;
    logic [23:0] sh_a;
    exp_t        e_a;

    always @(negedge clk) begin
        cyc_a++;
        if (rst_a) begin
            in_a        = 1'b0;
            have_fall_a = 1'b0;
            sb.delete();
        end else begin
            if (pcsn_a && !csn_a) begin
                in_a = 1'b1; lo_a = 0; rises_a = 0; unst_a = 0; sh_a = '0;
                per_a = have_fall_a ? cyc_a - fall_a : 0;
                fall_a = cyc_a; have_fall_a = 1'b1;
            end
            if (in_a && !csn_a) begin
                lo_a++;
                if (!psclk_a && sclk_a) begin
                    rises_a++;
                    sh_a = {sh_a[22:0], sdio_a};
                    if (sdio_a !== psdio_a) unst_a++;
                end
            end
            if (in_a && !pcsn_a && csn_a) begin
                in_a = 1'b0;
                cap.push_back(sh_a);
                if (sb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL frame_unexpected: got 0x%06h expected no frame", sh_a);
                end else begin
                    e_a = sb.pop_front();
                    check("frame_data", 32'(sh_a), 32'(e_a.frame));
                    check("csn_low_cycles", lo_a, 49 * A_DIV);
                    check("sclk_rises", rises_a, 24);
                    check("sdio_stable", unst_a, 0);
                    if (e_a.period != 0) check("frame_period", per_a, e_a.period);
                end
            end
        end
        pcsn_a = csn_a; psclk_a = sclk_a; psdio_a = sdio_a;
    end

    // ---------------- monitor B ----------------
    logic        pcsn_b = 1'b1, psclk_b = 1'b0, in_b = 1'b0;
    logic [23:0] sh_b;
    logic [9:0]  ib;
    int          nb = 0;

    always @(negedge clk) begin
        if (rst_b) in_b = 1'b0;
        if (start_b) nb = 0;
        if (pcsn_b && !csn_b) begin in_b = 1'b1; sh_b = '0; end
        if (in_b && !csn_b && !psclk_b && sclk_b) sh_b = {sh_b[22:0], sdio_b};
        if (in_b && !pcsn_b && csn_b) begin
            in_b = 1'b0;
            ib = 10'(nb);
            check("b_frame_data", 32'(sh_b), {8'h00, 6'd0, ib, ~ib[7:0]});
            nb++;
        end
        pcsn_b = csn_b; psclk_b = sclk_b;
    end

    // ---------------- stimulus ----------------
    task automatic pulse_start_a();
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
    endtask

    task automatic pulse_start_b();
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
    endtask

    task automatic wait_done_a(input int budget, input string name);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done_a) break;
        end
        check(name, done_a, 1);
    endtask

    task automatic run_a();
        logic found;
        // production table, with an ignored start mid-run
        mode_a = 0; cap.delete(); push_prod();
        pulse_start_a();
        check("a_busy_on_start", busy_a, 1);
        check("a_done_cleared", done_a, 0);
        repeat (3000) @(posedge clk);
        #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        check("a_busy_after_ignored_start", busy_a, 1);
        wait_done_a(12000, "a_prod_done");
        check("a_prod_err", err_a, 0);
        check("a_prod_busy", busy_a, 0);
        check("a_prod_sb_empty", sb.size(), 0);
        check("a_prod_nframes", cap.size(), 76);
        check("a_prod_frame0", 32'(cap_at(0)), 32'h000018);
        check("a_prod_frame5_addr_trunc", 32'(cap_at(5)), 32'h00F03C);
        check("a_prod_frame67", 32'(cap_at(67)), 32'h023200);
        check("a_prod_frame75", 32'(cap_at(75)), 32'h023201);

        // terminator at index 0
        mode_a = 4; cap.delete();
        pulse_start_a();
        repeat (11) @(posedge clk);
        #1 check("a_term0_done_early", done_a, 0);
        check("a_term0_busy_early", busy_a, 1);
        @(posedge clk); #1;
        check("a_term0_done", done_a, 1);
        check("a_term0_busy", busy_a, 0);
        check("a_term0_err", err_a, 0);
        check("a_term0_nframes", cap.size(), 0);

        // IO-update detection: data[0]=1 stretches the gap, data[0]=0 does not
        for (int m = 1; m <= 2; m++) begin
            mode_a = m; cap.delete();
            sb.push_back('{(m == 1) ? 24'h023201 : 24'h023200, 0});
            sb.push_back('{24'h00855A, (m == 1) ? A_PER + A_UW : A_PER});
            pulse_start_a();
            wait_done_a(1000, "a_upd_done");
            check("a_upd_sb_empty", sb.size(), 0);
            check("a_upd_nframes", cap.size(), 2);
        end

        // reset in frame 5, after 10 bits
        mode_a = 0; cap.delete(); push_prod();
        pulse_start_a();
        found = 1'b0;
        for (int k = 0; k < 2000 && !found; k++) begin
            @(negedge clk);
            if (cap.size() == 5 && in_a && rises_a == 10) found = 1'b1;
        end
        check("a_reach_frame5_bit10", found, 1);
        @(posedge clk); #1 rst_a = 1'b1;
        @(posedge clk); #1;
        check("a_rst_csn", csn_a, 1);
        check("a_rst_sclk", sclk_a, 0);
        check("a_rst_sdio", sdio_a, 0);
        check("a_rst_index", idx_a, 0);
        check("a_rst_busy", busy_a, 0);
        rst_a = 1'b0;
        check("a_rst_nframes", cap.size(), 5);

        cap.delete(); push_prod();
        pulse_start_a();
        wait_done_a(12000, "a_rerun_done");
        check("a_rerun_nframes", cap.size(), 76);
        check("a_rerun_frame0", 32'(cap_at(0)), 32'h000018);
        check("a_rerun_sb_empty", sb.size(), 0);
        check("a_rerun_err", err_a, 0);
    endtask

    task automatic run_b();
        pulse_start_b();
        for (int k = 0; k < 60000; k++) begin
            @(negedge clk);
            if (done_b) break;
        end
        check("b_done", done_b, 1);
        check("b_err", err_b, 1);
        check("b_busy", busy_b, 0);
        check("b_nframes", nb, 1024);
        check("b_last_index", idx_b, 10'd1023);
        pulse_start_b();
        check("b_restart_done_clr", done_b, 0);
        check("b_restart_err_clr", err_b, 0);
        check("b_restart_busy", busy_b, 1);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (nb == 1) break;
        end
        check("b_restart_first_frame", nb, 1);
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0; mode_a = 0;
        repeat (3) @(posedge clk);
        #1;
        check("a_reset_csn", csn_a, 1);
        check("a_reset_sclk", sclk_a, 0);
        check("a_reset_sdio", sdio_a, 0);
        check("a_reset_index", idx_a, 0);
        check("a_reset_busy", busy_a, 0);
        check("a_reset_done", done_a, 0);
        check("a_reset_err", err_a, 0);
        check("b_reset_csn", csn_b, 1);
        check("b_reset_done", done_b, 0);
        check("b_reset_err", err_b, 0);
        rst_a = 1'b0; rst_b = 1'b0;
        fork
            run_a();
            run_b();
        join
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
